// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg: shared constants, state encoding and request checks. Rev 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int         BEATS     = 4;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Illegal width for the direction, or an access that straddles its natural alignment.
  function automatic logic req_error(input logic write, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (write) begin
      case (funct3)
        F3_B:    err = 1'b0;
        F3_H:    err = addr_lo[0];
        F3_W:    err = |addr_lo;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = addr_lo[0];
        F3_W:        err = |addr_lo;
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_lane: load lane extraction/extension and sub-word store merge. Rev 1.0
// ----------------------------------------------------------------------------
module lsu_lane (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  import lsu_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase

    // Only SB/SH reach the merge; everything that is not a byte is a halfword.
    merged = rdata;
    if (funct3 == F3_B) begin
      merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    end else begin
      merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit: sequences 4-beat data-memory accesses for loads/stores. Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  import lsu_pkg::*;

  state_t      state;
  logic [1:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        write_q;
  logic        err_q;
  logic [31:0] load_data;
  logic [31:0] merged;

  // mem_wdata doubles as the store-data holding register until the merge overwrites it.
  lsu_lane u_lane (
    .funct3    (funct3_q),
    .addr_lo   (addr_lo_q),
    .rdata     (mem_rdata),
    .wdata     (mem_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  assign busy      = (state != ST_IDLE);
  assign mem_read  = (state == ST_RD);
  assign mem_write = (state == ST_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            addr_lo_q <= req_addr[1:0];
            funct3_q  <= req_funct3;
            write_q   <= req_write;
            err_q     <= req_error(req_write, req_funct3, req_addr[1:0]);
            cnt       <= 2'd0;
            if (req_write) begin
              mem_wdata <= req_wdata;
            end
            if (req_error(req_write, req_funct3, req_addr[1:0])) begin
              state <= ST_FIN;
            end else if (req_write && (req_funct3 == F3_W)) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          cnt <= cnt + 2'd1;
          if (cnt == LAST_BEAT) begin
            state <= write_q ? ST_MERGE : ST_FIN;
          end
        end
        ST_MERGE: begin
          mem_wdata <= merged;
          state     <= ST_WR;
        end
        ST_WR: begin
          cnt <= cnt + 2'd1;
          if (cnt == LAST_BEAT) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (write_q || err_q) ? 32'd0 : load_data;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit: randomized scoreboard bench with a word-array memory model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cycles = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model over a plain word array. Latencies count edges from the
  // accepting edge to the edge that raises resp_valid.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [31:0] rdata, output int lat);
    int size, off;
    logic legal;
    logic [31:0] word, v, mask, nw;
    off   = int'(addr[1:0]);
    size  = 1 << (int'(f3) % 4);
    legal = wr ? (f3 <= 3'd2) : ((f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || ((off % size) != 0);
    word  = ref_mem[addr[5:2]];
    rdata = 32'd0;
    lat   = 1;
    if (!err && !wr) begin
      lat = 5;
      if (size == 1) begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2) begin
        v = (word >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = word;
      end
      rdata = v;
    end else if (!err) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << (8 * off));
      nw   = (word & ~mask) | ((wdata << (8 * off)) & mask);
      ref_mem[addr[5:2]] = nw;
      wq.push_back('{addr & ~32'd3, nw});
      lat = (size == 4) ? 5 : 10;
    end
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit force_exp = 1'b0,
                       input logic [31:0] exp_rd = 32'd0, input logic exp_err = 1'b0);
    resp_t r;
    logic e;
    logic [31:0] d;
    int l;
    wait_idle();
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    model(wr, f3, addr, wdata, e, d, l);
    if (force_exp) begin
      d = exp_rd;
      e = exp_err;
    end
    r.err = e; r.rdata = d; r.acc = cyc + 1; r.lat = l;
    rq.push_back(r);
    @(posedge clk);
    #1;
    // Keep presenting junk while busy; it must be ignored.
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n;
    wait_idle();
    req_valid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d, required 0", rq.size());
      rq.delete();
    end
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    phys_mem[addr[5:2]] = val;
    ref_mem[addr[5:2]]  = val;
  endtask

  // Response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
        end else begin
          r = rq.pop_front();
          check32("resp_err", 32'(resp_err), 32'(r.err));
          check32("resp_rdata", resp_rdata, r.rdata);
          check32("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
    end
  end

  // Data-memory responder and protocol checker
  int          rd_run = 0;
  int          wr_run = 0;
  logic [31:0] rd_addr, wr_addr, wr_data;
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_run = 0;
        wr_run = 0;
        mem_rdata = $urandom;
      end else begin
        if (mem_read || mem_write) begin
          strobe_cycles++;
          check32("single_strobe", 32'(mem_read && mem_write), 32'd0);
        end
        if (mem_read) begin
          if (rd_run == 0) rd_addr = mem_addr;
          else check32("rd_addr_stable", mem_addr, rd_addr);
          rd_run++;
          mem_rdata = $urandom;
        end else if (rd_run != 0) begin
          check32("rd_beats", 32'(rd_run), 32'd4);
          mem_rdata = phys_mem[rd_addr[5:2]];
          rd_run = 0;
        end else begin
          mem_rdata = $urandom;
        end
        if (mem_write) begin
          if (wr_run == 0) begin
            wr_addr = mem_addr;
            wr_data = mem_wdata;
          end else begin
            check32("wr_addr_stable", mem_addr, wr_addr);
            check32("wr_data_stable", mem_wdata, wr_data);
          end
          wr_run++;
        end else if (wr_run != 0) begin
          check32("wr_beats", 32'(wr_run), 32'd4);
          phys_mem[wr_addr[5:2]] = wr_data;
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h", wr_addr, wr_data);
          end else begin
            w = wq.pop_front();
            check32("wr_addr", wr_addr, w.addr);
            check32("wr_data", wr_data, w.data);
          end
          wr_run = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a, old;
    logic [2:0]  load_f3 [5];
    int          k, n, s0, hits;
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end

    // Reset state
    #13;
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check32("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check32("rst_rdata", resp_rdata, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word load, byte loads with sign/zero extension, byte store merge
    set_word(32'h100, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
    drain();
    set_word(32'h100, 32'h80FF1234);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1'b1, 32'h00000080, 1'b0);
    drain();
    set_word(32'h200, 32'h11223344);
    issue(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB);
    drain();
    check32("sb_merged_word", phys_mem[0], 32'h1122AB44);

    // Misaligned requests finish without touching memory
    s0 = strobe_cycles;
    issue(1'b0, 3'b010, 32'h0000_0102, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 3'b001, 32'h0000_0105, 32'h1234, 1'b1, 32'd0, 1'b1);
    drain();
    check32("err_no_strobe", 32'(strobe_cycles - s0), 32'd0);

    // Reset during the third write beat abandons the store
    old = ref_mem[0];
    issue(1'b1, 3'b010, 32'h0000_0300, 32'hCAFEF00D);
    k = 0;
    n = 0;
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_write) k++;
    end
    check32("wr_beat_reached", 32'(k), 32'd3);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check32("midrst_mem_write", 32'(mem_write), 32'd0);
    check32("midrst_busy", 32'(busy), 32'd0);
    check32("midrst_resp_valid", 32'(resp_valid), 32'd0);
    rq.delete();
    wq.delete();
    ref_mem[0] = old;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid || mem_write || mem_read) hits++;
    end
    check32("post_rst_quiet", 32'(hits), 32'd0);
    check32("abandoned_store", phys_mem[0], old);
    issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
    drain();

    // Randomized traffic, mostly back-to-back
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        f3 = wr ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        else if (f3[1:0] == 2'd1) a[0] = 1'b0;
      end
      issue(wr, f3, a, $urandom);
      if ($urandom_range(0, 7) == 0) begin
        drain();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();
    repeat (4) @(negedge clk);
    check32("writes_outstanding", 32'(wq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
